// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, default widths and halt encoding for the fetch sequencer
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;
  localparam int DEF_AW = 9;
  localparam int DEF_IW = 9;
  localparam logic [DEF_IW-1:0] DEF_HALT = 9'h1FF;
  typedef logic [DEF_AW-1:0] prog_tbl_t [4];
endpackage

// File: rtl/fetch_if.sv
// fetch_if: host/ROM-facing signals of the fetch sequencer
interface fetch_if import fetch_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int IW = DEF_IW,
  parameter int CW = 16
);
  logic          req;
  logic [1:0]    prog_sel;
  logic          ack;
  logic          abort;
  logic          stall;
  logic          branch;
  logic          taken;
  logic [AW-1:0] target;
  logic [IW-1:0] instr_in;
  logic [AW-1:0] pc_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] instr_count;
  modport master(output req, prog_sel, ack, abort, stall, branch, taken, target, instr_in,
                 input pc_out, busy, done, cycle_count, instr_count);
  modport slave(input req, prog_sel, ack, abort, stall, branch, taken, target, instr_in,
                output pc_out, busy, done, cycle_count, instr_count);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: launches one of four programs, steps the PC with stall/branch until halt, then waits for ack
module fetch_ctrl import fetch_pkg::*; #(
  parameter int            AW         = DEF_AW,
  parameter int            IW         = DEF_IW,
  parameter logic [IW-1:0] HALT_INSTR = DEF_HALT,
  parameter int            PROG0_ADDR = 0,
  parameter int            PROG1_ADDR = 128,
  parameter int            PROG2_ADDR = 256,
  parameter int            PROG3_ADDR = 384,
  parameter int            CW         = 16
) (
  input logic   clk,
  input logic   reset,
  fetch_if.slave bus
);
  localparam logic [AW-1:0] PROG_TBL [4] = '{AW'(PROG0_ADDR), AW'(PROG1_ADDR), AW'(PROG2_ADDR), AW'(PROG3_ADDR)};
  state_t        state, state_nx;
  logic [1:0]    sel;
  logic [AW-1:0] pc, pc_nx;
  logic          clr, cyc_inc, ins_inc;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      sel   <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (state == IDLE && bus.req) sel <= bus.prog_sel;
    end
  // RUN priority: abort > halt > stall > taken branch > increment
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    clr      = 1'b0;
    cyc_inc  = 1'b0;
    ins_inc  = 1'b0;
    case (state)
      IDLE:   state_nx = bus.req ? LAUNCH : IDLE;
      LAUNCH: begin
        pc_nx    = PROG_TBL[sel];
        clr      = 1'b1;
        state_nx = bus.abort ? IDLE : RUN;
      end
      RUN:
        if (bus.abort) state_nx = IDLE;
        else if (bus.instr_in == HALT_INSTR) begin
          state_nx = DONE;
          cyc_inc  = 1'b1;
        end else begin
          cyc_inc = 1'b1;
          ins_inc = !bus.stall;
          pc_nx   = bus.stall ? pc : (bus.branch && bus.taken) ? bus.target : pc + 1'b1;
        end
      DONE:    state_nx = bus.ack ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  assign bus.pc_out = pc;
  assign bus.busy   = state == LAUNCH || state == RUN;
  assign bus.done   = state == DONE;
  sat_counter #(.CW(CW)) u_cycle (.clk(clk), .rst(reset), .clr(clr), .inc(cyc_inc), .count(bus.cycle_count));
  sat_counter #(.CW(CW)) u_instr (.clk(clk), .rst(reset), .clr(clr), .inc(ins_inc), .count(bus.instr_count));
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios for fetch_ctrl with a bench-side instruction ROM
module tb_fetch_ctrl;
  localparam logic [8:0] HALT = 9'h1FF;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int errors = 0;
  logic [8:0] mem [512];
  logic sc_clr, sc_inc;
  logic [3:0] sc_count;

  fetch_if #(.AW(9), .IW(9), .CW(16)) bus ();
  fetch_ctrl #(.PROG3_ADDR(510)) dut (.clk(clk), .reset(reset), .bus(bus));
  sat_counter #(.CW(4)) sc (.clk(clk), .rst(reset), .clr(sc_clr), .inc(sc_inc), .count(sc_count));

  assign bus.instr_in = mem[bus.pc_out];
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) mem[i] = 9'h000;
  endtask

  task automatic launch(input logic [1:0] p);
    bus.req = 1'b1;
    bus.prog_sel = p;
    tick();
    bus.req = 1'b0;
    tick();
  endtask

  task automatic run_to_done(input string name, input int bound);
    int n;
    n = 0;
    while (!bus.done && n < bound) begin
      tick();
      n++;
    end
    vectors++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL %s: done not reached within %0d cycles", name, bound); end
  endtask

  task automatic acknowledge();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (bus.pc_out !== 9'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", bus.pc_out); end
    vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", bus.busy, bus.done); end
    vectors++; if (bus.cycle_count !== 16'd0 || bus.instr_count !== 16'd0) begin errors++; $display("FAIL reset_counts: cyc=%0d ins=%0d want 0 0", bus.cycle_count, bus.instr_count); end
  endtask

  task automatic test_launch_halt();
    clear_rom();
    mem[132] = HALT;
    bus.req = 1'b1;
    bus.prog_sel = 2'd1;
    tick();
    bus.req = 1'b0;
    vectors++; if (bus.busy !== 1'b1 || bus.pc_out !== 9'd0) begin errors++; $display("FAIL launch_state: busy=%b pc=%0d want 1 0", bus.busy, bus.pc_out); end
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++; if (bus.pc_out !== 9'(128 + i)) begin errors++; $display("FAIL launch_seq[%0d]: pc=%0d want %0d", i, bus.pc_out, 128 + i); end
      tick();
    end
    vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pc_out !== 9'd132) begin errors++; $display("FAIL halt_state: done=%b busy=%b pc=%0d want 1 0 132", bus.done, bus.busy, bus.pc_out); end
    vectors++; if (bus.instr_count !== 16'd4 || bus.cycle_count !== 16'd5) begin errors++; $display("FAIL halt_counts: ins=%0d cyc=%0d want 4 5", bus.instr_count, bus.cycle_count); end
    tick();
    vectors++; if (bus.done !== 1'b1 || bus.pc_out !== 9'd132 || bus.cycle_count !== 16'd5) begin errors++; $display("FAIL done_hold: done=%b pc=%0d cyc=%0d want 1 132 5", bus.done, bus.pc_out, bus.cycle_count); end
    acknowledge();
    vectors++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ack_idle: done=%b busy=%b want 0 0", bus.done, bus.busy); end
  endtask

  task automatic test_branch();
    logic [8:0] seq [9];
    seq = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd16, 9'd17, 9'd18};
    clear_rom();
    mem[18] = HALT;
    bus.target = 9'd16;
    bus.taken = 1'b1;
    launch(2'd0);
    for (int i = 0; i < 9; i++) begin
      vectors++; if (bus.pc_out !== seq[i]) begin errors++; $display("FAIL branch_seq[%0d]: pc=%0d want %0d", i, bus.pc_out, seq[i]); end
      bus.branch = bus.pc_out == 9'd5;
      tick();
      bus.branch = 1'b0;
    end
    vectors++; if (bus.done !== 1'b1 || bus.instr_count !== 16'd8 || bus.cycle_count !== 16'd9) begin errors++; $display("FAIL branch_end: done=%b ins=%0d cyc=%0d want 1 8 9", bus.done, bus.instr_count, bus.cycle_count); end
    acknowledge();
    bus.taken = 1'b0;
    launch(2'd0);
    for (int i = 0; i < 6; i++) begin
      bus.branch = bus.pc_out == 9'd5;
      tick();
      bus.branch = 1'b0;
    end
    vectors++; if (bus.pc_out !== 9'd6) begin errors++; $display("FAIL not_taken: pc=%0d want 6", bus.pc_out); end
    run_to_done("not_taken_run", 40);
    vectors++; if (bus.instr_count !== 16'd18 || bus.cycle_count !== 16'd19) begin errors++; $display("FAIL not_taken_counts: ins=%0d cyc=%0d want 18 19", bus.instr_count, bus.cycle_count); end
    acknowledge();
  endtask

  task automatic test_stall();
    clear_rom();
    mem[4] = HALT;
    launch(2'd0);
    tick();
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (bus.pc_out !== 9'd2) begin errors++; $display("FAIL stall_hold[%0d]: pc=%0d want 2", i, bus.pc_out); end
    end
    bus.stall = 1'b0;
    run_to_done("stall_run", 10);
    vectors++; if (bus.instr_count !== 16'd4 || bus.cycle_count !== 16'd8) begin errors++; $display("FAIL stall_counts: ins=%0d cyc=%0d want 4 8", bus.instr_count, bus.cycle_count); end
    acknowledge();
    launch(2'd0);
    tick();
    bus.stall = 1'b1;
    bus.branch = 1'b1;
    bus.taken = 1'b1;
    bus.target = 9'd40;
    tick();
    bus.stall = 1'b0;
    bus.branch = 1'b0;
    bus.taken = 1'b0;
    vectors++; if (bus.pc_out !== 9'd1) begin errors++; $display("FAIL stall_over_branch: pc=%0d want 1", bus.pc_out); end
    run_to_done("stall_branch_run", 10);
    vectors++; if (bus.instr_count !== 16'd4 || bus.cycle_count !== 16'd6) begin errors++; $display("FAIL stall_branch_counts: ins=%0d cyc=%0d want 4 6", bus.instr_count, bus.cycle_count); end
    acknowledge();
  endtask

  task automatic test_wrap();
    logic [8:0] seq [4];
    seq = '{9'd510, 9'd511, 9'd0, 9'd1};
    clear_rom();
    mem[1] = HALT;
    launch(2'd3);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bus.pc_out !== seq[i]) begin errors++; $display("FAIL wrap_seq[%0d]: pc=%0d want %0d", i, bus.pc_out, seq[i]); end
      tick();
    end
    vectors++; if (bus.done !== 1'b1 || bus.instr_count !== 16'd3 || bus.cycle_count !== 16'd4) begin errors++; $display("FAIL wrap_end: done=%b ins=%0d cyc=%0d want 1 3 4", bus.done, bus.instr_count, bus.cycle_count); end
    acknowledge();
  endtask

  task automatic test_abort_reset();
    clear_rom();
    launch(2'd1);
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pc_out !== 9'd130) begin errors++; $display("FAIL abort_idle: busy=%b done=%b pc=%0d want 0 0 130", bus.busy, bus.done, bus.pc_out); end
    for (int i = 0; i < 3; i++) tick();
    vectors++; if (bus.done !== 1'b0 || bus.pc_out !== 9'd130 || bus.instr_count !== 16'd2 || bus.cycle_count !== 16'd2) begin errors++; $display("FAIL abort_frozen: done=%b pc=%0d ins=%0d cyc=%0d want 0 130 2 2", bus.done, bus.pc_out, bus.instr_count, bus.cycle_count); end
    launch(2'd1);
    tick();
    #3 reset = 1'b1;
    #1;
    vectors++; if (bus.pc_out !== 9'd0 || bus.busy !== 1'b0 || bus.cycle_count !== 16'd0 || bus.instr_count !== 16'd0) begin errors++; $display("FAIL async_reset: pc=%0d busy=%b cyc=%0d ins=%0d want 0 0 0 0", bus.pc_out, bus.busy, bus.cycle_count, bus.instr_count); end
    #2 reset = 1'b0;
    tick();
    vectors++; if (bus.busy !== 1'b0 || bus.pc_out !== 9'd0) begin errors++; $display("FAIL post_reset_idle: busy=%b pc=%0d want 0 0", bus.busy, bus.pc_out); end
  endtask

  task automatic test_handshake();
    clear_rom();
    mem[132] = HALT;
    launch(2'd1);
    run_to_done("handshake_run", 10);
    bus.req = 1'b1;
    bus.prog_sel = 2'd2;
    tick();
    tick();
    vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pc_out !== 9'd132) begin errors++; $display("FAIL req_in_done: done=%b busy=%b pc=%0d want 1 0 132", bus.done, bus.busy, bus.pc_out); end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    vectors++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL req_on_ack: done=%b busy=%b want 0 0", bus.done, bus.busy); end
    tick();
    bus.req = 1'b0;
    vectors++; if (bus.busy !== 1'b1 || bus.pc_out !== 9'd132) begin errors++; $display("FAIL relaunch_from_idle: busy=%b pc=%0d want 1 132", bus.busy, bus.pc_out); end
    tick();
    vectors++; if (bus.pc_out !== 9'd256 || bus.cycle_count !== 16'd0) begin errors++; $display("FAIL relaunch_addr: pc=%0d cyc=%0d want 256 0", bus.pc_out, bus.cycle_count); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic test_saturate();
    sc_inc = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    vectors++; if (sc_count !== 4'd14) begin errors++; $display("FAIL sat_below: count=%0d want 14", sc_count); end
    for (int i = 0; i < 6; i++) tick();
    vectors++; if (sc_count !== 4'd15) begin errors++; $display("FAIL sat_top: count=%0d want 15", sc_count); end
    sc_inc = 1'b0;
    sc_clr = 1'b1;
    tick();
    sc_clr = 1'b0;
    vectors++; if (sc_count !== 4'd0) begin errors++; $display("FAIL sat_clear: count=%0d want 0", sc_count); end
  endtask

  initial begin
    bus.req = 1'b0;
    bus.prog_sel = 2'd0;
    bus.ack = 1'b0;
    bus.abort = 1'b0;
    bus.stall = 1'b0;
    bus.branch = 1'b0;
    bus.taken = 1'b0;
    bus.target = 9'd0;
    sc_clr = 1'b0;
    sc_inc = 1'b0;
    clear_rom();
    #12;
    test_reset();
    reset = 1'b0;
    tick();
    test_launch_halt();
    test_branch();
    test_stall();
    test_wrap();
    test_abort_reset();
    test_handshake();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencer for instruction fetch. Owns the program counter and launches one of four programs from a start-address table on request.
- Runs the program, applying stall and branch redirects, until it fetches the halt instruction. It then raises done and waits for acknowledge.
- Sits between the top-level test/host interface and the instruction ROM. pc_out drives the ROM address; the ROM's combinational output returns on instr_in in the same cycle.

Parameters:
- AW, 9, PC/instruction-address width
- IW, 9, instruction width
- HALT_INSTR, 9'h1FF, encoding that terminates a program
- PROG0_ADDR, 0, start address of program 0
- PROG1_ADDR, 128, start address of program 1
- PROG2_ADDR, 256, start address of program 2
- PROG3_ADDR, 384, start address of program 3
- CW, 16, width of cycle/instruction counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  launch request, sampled in IDLE
- prog_sel  in  2  program index, latched with req
- ack  in  1  host acknowledge of done
- abort  in  1  cancel the running program
- stall  in  1  hold the PC this cycle (RUN only)
- branch  in  1  current instruction is a branch
- taken  in  1  branch condition true
- target  in  AW  branch target address
- instr_in  in  IW  ROM data for pc_out
- pc_out  out  AW  current fetch address
- busy  out  1  high in LAUNCH or RUN
- done  out  1  high in DONE
- cycle_count  out  CW  RUN cycles of the last/current program
- instr_count  out  CW  instructions retired (halt excluded)

Behaviour:
- Reset: async, forces state to IDLE. pc_out=0, busy=0, done=0, cycle_count=0, instr_count=0, latched sel=0.
- States: IDLE, LAUNCH, RUN, DONE. Transitions are registered on the clk rising edge. Outputs are registered or decoded from state.
- IDLE:
  - PC and counters hold.
  - When req=1, latch prog_sel and go to LAUNCH.
  - ack, abort, stall and branch are ignored.
- LAUNCH (exactly 1 cycle):
  - pc <= PROGn_ADDR[sel]; cycle_count <= 0; instr_count <= 0.
  - Go to RUN; abort=1 goes to IDLE instead, with PC and counters still updated.
- RUN, priority per cycle: abort > halt > stall > branch&&taken > increment.
  - abort: go to IDLE; PC and counters hold; done is not raised.
  - halt (instr_in==HALT_INSTR): go to DONE; PC holds at the halt address; instr_count unchanged; cycle_count increments.
  - stall: PC holds; cycle_count increments; instr_count holds.
  - branch&&taken: pc <= target; both counters increment.
  - Otherwise: pc <= pc+1 modulo 2^AW (511 -> 0); both counters increment. branch=1 with taken=0 takes this path.
- DONE:
  - done=1; PC and counters hold and remain readable.
  - When ack=1, go to IDLE with done falling the next cycle.
  - req is ignored in DONE, including the ack cycle; the host must reassert req in IDLE.
- Counters saturate at 2^CW-1; no wrap.
- Latency: req high at edge N puts the launch address on pc_out after edge N+1. The first instruction is retired or halted in the cycle after that.
- Reset mid-RUN returns immediately to IDLE with every output at its reset value.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, LAUNCH, RUN, DONE}
  - AW/IW defaults
  - HALT_INSTR constant
  - prog-address table type (array of 4 x AW)
- One sub-module: sat_counter (parameter CW; inputs clr, inc; output count; async active-high reset), instantiated twice for cycle_count and instr_count.

Test Plan:
1. Launch and halt:
   - Stimulus: reset, then req=1 with prog_sel=1; bench ROM holds NOPs at 128..131 and HALT at 132.
   - Required response: pc_out steps 128..132 and stops; done=1; instr_count=4; cycle_count=5.
   - Then ack=1 returns to IDLE and done=0 the next cycle.
2. Branch:
   - Stimulus: program 0 with branch=1, taken=1, target=16 at pc=5, HALT at 18.
   - Required response: pc sequence 0..5, 16, 17, 18; instr_count=8.
   - Repeat with taken=0: pc goes 5 -> 6.
3. Stall:
   - Stimulus: stall=1 for 3 cycles at pc=2.
   - Required response: pc_out holds at 2 for those 3 cycles; cycle_count exceeds instr_count by 3 extra at the halt.
   - Stimulus: stall and branch&&taken in the same cycle.
   - Required response: PC holds (stall wins).
4. Wrap:
   - Stimulus: PROG3_ADDR=510, no halt until address 1.
   - Required response: pc 510, 511, 0, 1; done=1.
5. Abort and reset:
   - Stimulus: abort=1 at pc=130.
   - Required response: IDLE next cycle, done never asserted, counters frozen.
   - Stimulus: async reset pulse mid-RUN between clock edges.
   - Required response: pc_out=0, busy=0 immediately.
6. Handshake edges:
   - Stimulus: req=1 held during DONE and the ack cycle.
   - Required response: no relaunch until IDLE is reached.
   - Stimulus: counter driven to 65535.
   - Required response: counter stays at 65535.
